branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB plus a pattern table of saturating
// counters. The pattern table is indexed by PC bits (bimodal) or by PC bits
// XOR the global history (gshare). Lookup is purely combinational. Update,
// history and the statistics counters commit on the rising clock edge.
//
// Ports:
//   CLK, resetl           clock; asynchronous active-high reset
//   pc_IF                 fetch PC to look up
//   pred_taken_IF         predicted direction for pc_IF
//   pred_target_IF        predicted next fetch PC
//   ghr_IF                current global history, carried down the pipe
//   update_valid_MEM      a resolved branch is in MEM this cycle
//   pc_MEM, target_MEM    resolved branch PC and computed target
//   taken_MEM, uncond_MEM resolved direction, unconditional flag
//   pred_*_MEM, ghr_MEM   prediction and history carried with the branch
//   mispredict_MEM        redirect required (combinational)
//   redirect_pc_MEM       correct next PC
//   branch_count          resolved branches seen (saturating)
//   mispredict_count      mispredictions seen (saturating)
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int HIST_W  = 4
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [63:0]       pc_IF,
  output logic              pred_taken_IF,
  output logic [63:0]       pred_target_IF,
  output logic [HIST_W-1:0] ghr_IF,
  input  logic              update_valid_MEM,
  input  logic [63:0]       pc_MEM,
  input  logic [63:0]       target_MEM,
  input  logic              taken_MEM,
  input  logic              uncond_MEM,
  input  logic              pred_taken_MEM,
  input  logic [63:0]       pred_target_MEM,
  input  logic [HIST_W-1:0] ghr_MEM,
  output logic              mispredict_MEM,
  output logic [63:0]       redirect_pc_MEM,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 64 - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0]            uncond_q, uncond_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][63:0]      tgt_q, tgt_d;
  logic [ENTRIES-1:0][CTR_W-1:0] ctr_q, ctr_d;
  logic [HIST_W-1:0]             ghr_q, ghr_d;
  logic [31:0]                   branch_count_q, branch_count_d;
  logic [31:0]                   mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] if_idx, if_pidx, mem_idx, mem_pidx;
  logic [TAG_W-1:0] if_tag, mem_tag;
  logic             if_hit, mem_hit;

  // Low PC bits are always zero for aligned instructions and never index.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pc_IF[1:0], pc_MEM[1:0]};

  assign if_idx  = pc_IF[IDX_W+1:2];
  assign if_tag  = pc_IF[63:IDX_W+2];
  assign mem_idx = pc_MEM[IDX_W+1:2];
  assign mem_tag = pc_MEM[63:IDX_W+2];

  // gshare folds history into the pattern index: live history for lookup,
  // the history the branch was predicted with for update.
  assign if_pidx  = (MODE == 1) ? (if_idx ^ IDX_W'(ghr_q))    : if_idx;
  assign mem_pidx = (MODE == 1) ? (mem_idx ^ IDX_W'(ghr_MEM)) : mem_idx;

  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

  assign pred_taken_IF  = if_hit && (uncond_q[if_idx] || ctr_q[if_pidx][CTR_W-1]);
  assign pred_target_IF = pred_taken_IF ? tgt_q[if_idx] : pc_IF + 64'd4;
  assign ghr_IF         = ghr_q;

  assign mispredict_MEM  = update_valid_MEM &&
                           ((taken_MEM != pred_taken_MEM) ||
                            (taken_MEM && (target_MEM != pred_target_MEM)));
  assign redirect_pc_MEM = taken_MEM ? target_MEM : pc_MEM + 64'd4;

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  always_comb begin
    valid_d            = valid_q;
    uncond_d           = uncond_q;
    tag_d              = tag_q;
    tgt_d              = tgt_q;
    ctr_d              = ctr_q;
    ghr_d              = ghr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (update_valid_MEM) begin
      if (taken_MEM) begin
        tgt_d[mem_idx] = target_MEM;
        if (mem_hit) begin
          if (ctr_q[mem_pidx] != CTR_MAX) ctr_d[mem_pidx] = ctr_q[mem_pidx] + 1'b1;
        end else begin
          // Allocate/replace on a taken miss; start weakly taken.
          valid_d[mem_idx]  = 1'b1;
          tag_d[mem_idx]    = mem_tag;
          uncond_d[mem_idx] = uncond_MEM;
          ctr_d[mem_pidx]   = CTR_WT;
        end
      end else begin
        // Not-taken trains the counter even on a BTB miss.
        if (ctr_q[mem_pidx] != '0) ctr_d[mem_pidx] = ctr_q[mem_pidx] - 1'b1;
      end

      // Shift in the outcome; dropping the MSB of the concat covers HIST_W=1.
      if (MODE == 1) ghr_d = HIST_W'({ghr_q, taken_MEM});

      if (branch_count_q != '1) branch_count_d = branch_count_q + 32'd1;
      if (mispredict_MEM && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge resetl) begin
    if (resetl) begin
      valid_q            <= '0;
      uncond_q           <= '0;
      tag_q              <= '0;
      tgt_q              <= '0;
      ctr_q              <= {ENTRIES{CTR_WNT}};
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      uncond_q           <= uncond_d;
      tag_q              <= tag_d;
      tgt_q              <= tgt_d;
      ctr_q              <= ctr_d;
      ghr_q              <= ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
endmodule
